profile_sequencer: RTL

Custom-instruction controller that owns the command port of the four-counter profiling unit and runs one timed measurement window per request. The CPU arms a window length in cycles; the sequencer clears and enables all four counters, stops them after exactly N cycles, then reads all four values into a snapshot register file. The CPU polls status and reads snapshots through its own custom-instruction ID, without hand-issuing profile-unit commands.

---
 rtl/profile_seq_pkg.sv | 31 +++
 rtl/profile_seq_timer.sv | 33 +++
 rtl/profile_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/profile_seq_pkg.sv
// Shared types and constants for the profile sequencer: FSM encodings, CPU opcodes and
// the command words understood by the four-counter profiling unit.
package profile_seq_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_CLEAR = 3'd1;
   localparam state_t ST_RUN   = 3'd2;
   localparam state_t ST_STOP  = 3'd3;
   // Read states share their low bits with the counter index they fetch.
   localparam state_t ST_RD0   = 3'd4;
   localparam state_t ST_RD1   = 3'd5;
   localparam state_t ST_RD2   = 3'd6;
   localparam state_t ST_RD3   = 3'd7;

   localparam logic [1:0] OP_ARM    = 2'd0;
   localparam logic [1:0] OP_ABORT  = 2'd1;
   localparam logic [1:0] OP_STATUS = 2'd2;
   localparam logic [1:0] OP_READ   = 2'd3;

   localparam logic [31:0] CMD_CLEAR_EN = 32'h0000_0F0F;
   localparam logic [31:0] CMD_STOP     = 32'h0000_00F0;
   localparam logic [31:0] REJECT       = 32'hFFFF_FFFF;

   function automatic logic [31:0] status_word(input logic error, input logic valid,
                                               input logic busy);
      return {29'b0, error, valid, busy};
   endfunction

endpackage

// File: rtl/profile_seq_timer.sv
// 32-bit loadable down-counter that times the measurement window.
module profile_seq_timer (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_value,
   input  logic        decrement,
   output logic        is_one
);

   logic [31:0] count_q, count_d;

   // Saturate at zero so a stray decrement can never wrap the count.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (decrement && (count_q != 32'd0)) begin
         count_d = count_q - 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign is_one = (count_q == 32'd1);

endmodule

// File: rtl/profile_sequencer.sv
// Runs one timed measurement window on the profiling unit per ARM request and captures
// all four counters into a snapshot file the CPU can read back.
module profile_sequencer
   import profile_seq_pkg::*;
#(
   parameter logic [7:0] customId  = 8'h00,
   parameter logic [7:0] profileId = 8'h01
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ciStart,
   input  logic [7:0]  ciCin,
   input  logic [31:0] ciValueA,
   input  logic [31:0] ciValueB,
   output logic        ciDone,
   output logic [31:0] ciResult,
   output logic        profStart,
   output logic [7:0]  profCin,
   output logic [31:0] profValueA,
   output logic [31:0] profValueB,
   input  logic [31:0] profResult
);

   state_t      state_q, state_d;
   logic        valid_q, valid_d;
   logic        error_q, error_d;
   logic        abort_q, abort_d;
   logic [31:0] snap_q [4];

   logic        hit;
   logic [1:0]  op;
   logic        busy;
   logic        arm_ok;
   logic        abort_cmd;
   logic        timer_dec;
   logic        timer_is_one;
   logic        unused_value_a;

   assign hit            = ciStart && (ciCin == customId);
   assign op             = ciValueA[1:0];
   assign busy           = (state_q != ST_IDLE);
   assign arm_ok         = hit && (op == OP_ARM) && !busy && (ciValueB != 32'd0);
   assign abort_cmd      = hit && (op == OP_ABORT);
   assign unused_value_a = ^ciValueA[31:2];

   // CLEAR counts as the first window cycle, so the timer already runs there.
   assign timer_dec = ((state_q == ST_CLEAR) || (state_q == ST_RUN)) && !timer_is_one;

   profile_seq_timer u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (arm_ok),
      .load_value (ciValueB),
      .decrement  (timer_dec),
      .is_one     (timer_is_one)
   );

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      error_d = error_q;
      abort_d = abort_q;
      case (state_q)
         ST_CLEAR, ST_RUN: begin
            if (abort_cmd) begin
               state_d = ST_STOP;
               abort_d = 1'b1;
            end else if (timer_is_one) begin
               state_d = ST_STOP;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_STOP: begin
            state_d = abort_q ? ST_IDLE : ST_RD0;
            abort_d = 1'b0;
         end
         ST_RD0: state_d = ST_RD1;
         ST_RD1: state_d = ST_RD2;
         ST_RD2: state_d = ST_RD3;
         ST_RD3: begin
            state_d = ST_IDLE;
            valid_d = 1'b1;
         end
         default: begin
            if (arm_ok) begin
               state_d = ST_CLEAR;
            end
         end
      endcase
      if (hit && (op == OP_ARM)) begin
         if (arm_ok) begin
            valid_d = 1'b0;
            error_d = 1'b0;
         end else begin
            error_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         error_q <= 1'b0;
         abort_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            snap_q[i] <= 32'd0;
         end
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         error_q <= error_d;
         abort_q <= abort_d;
         if (state_q[2]) begin
            snap_q[state_q[1:0]] <= profResult;
         end
      end
   end

   always_comb begin
      profStart  = 1'b0;
      profValueA = 32'd0;
      profValueB = 32'd0;
      case (state_q)
         ST_CLEAR: begin
            profStart  = 1'b1;
            profValueB = CMD_CLEAR_EN;
         end
         ST_STOP: begin
            profStart  = 1'b1;
            profValueB = CMD_STOP;
         end
         ST_RD0, ST_RD1, ST_RD2, ST_RD3: begin
            profStart  = 1'b1;
            profValueA = {30'b0, state_q[1:0]};
         end
         default: ;
      endcase
      profCin = profStart ? profileId : 8'h00;
   end

   always_comb begin
      ciDone   = hit;
      ciResult = 32'd0;
      if (hit) begin
         case (op)
            OP_ARM:    if (!arm_ok) ciResult = REJECT;
            OP_STATUS: ciResult = status_word(error_q, valid_q, busy);
            OP_READ:   if (valid_q) ciResult = snap_q[ciValueB[1:0]];
            default:   ;
         endcase
      end
   end

endmodule
